// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Restoring division on magnitudes, signs applied on the final iteration; S/f handshake.
module booth_divider #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2*N-1:0]   IN1,
    input  logic [N-1:0]     IN2,
    input  logic             S,
    output logic             f,
    output logic [N-1:0]     Q,
    output logic [N-1:0]     R,
    output logic             ovf,
    output logic             dbz
);

    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0]  LAST_ITER = CW'(2*N-1);
    localparam logic [2*N-1:0] Q_POS_LIM = (2*N)'((1 << (N-1)) - 1);
    localparam logic [2*N-1:0] Q_NEG_LIM = (2*N)'(1 << (N-1));
    localparam logic [N-1:0]   SAT_POS   = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]   SAT_NEG   = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic            s_d_reg;
    logic [CW-1:0]   count_reg;
    logic [N:0]      rem_reg;
    logic [2*N-1:0]  quo_reg;
    logic [N:0]      dmag_reg;
    logic            sign_q_reg;
    logic            sign_r_reg;

    logic            start;
    logic [2*N-1:0]  dividend_mag;
    logic [N:0]      divisor_ext;
    logic [N:0]      divisor_mag;
    logic [N+1:0]    shifted;
    logic            take;
    logic [N:0]      rem_next;
    logic [2*N-1:0]  quo_next;
    logic [2*N-1:0]  q_limit;
    logic            ovf_next;
    logic [N-1:0]    q_final;
    logic [N-1:0]    r_final;

    assign start = S & ~s_d_reg;

    always_comb begin
        // Unsigned 2N bits is enough for |-2^(2N-1)|; divisor needs N+1 for |-2^(N-1)|.
        dividend_mag = IN1[2*N-1] ? -IN1 : IN1;
        divisor_ext  = {IN2[N-1], IN2};
        divisor_mag  = IN2[N-1] ? -divisor_ext : divisor_ext;

        shifted  = {rem_reg, quo_reg[2*N-1]};
        take     = (shifted >= {1'b0, dmag_reg});
        rem_next = take ? (shifted[N:0] - dmag_reg) : shifted[N:0];
        quo_next = {quo_reg[2*N-2:0], take};

        // Negative quotients may reach one step further than positive ones.
        q_limit  = sign_q_reg ? Q_NEG_LIM : Q_POS_LIM;
        ovf_next = (quo_next > q_limit);

        if (ovf_next) begin
            q_final = sign_q_reg ? SAT_NEG : SAT_POS;
        end else begin
            q_final = sign_q_reg ? -quo_next[N-1:0] : quo_next[N-1:0];
        end
        r_final = sign_r_reg ? -rem_next[N-1:0] : rem_next[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            s_d_reg    <= 1'b0;
            count_reg  <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dmag_reg   <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            f          <= 1'b0;
            Q          <= '0;
            R          <= '0;
            ovf        <= 1'b0;
            dbz        <= 1'b0;
        end else begin
            s_d_reg <= S;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        sign_q_reg <= IN1[2*N-1] ^ IN2[N-1];
                        sign_r_reg <= IN1[2*N-1];
                        count_reg  <= '0;
                        rem_reg    <= '0;
                        quo_reg    <= dividend_mag;
                        dmag_reg   <= divisor_mag;
                        if (IN2 == '0) begin
                            state_reg <= DONE;
                            Q         <= '0;
                            R         <= '0;
                            ovf       <= 1'b1;
                            dbz       <= 1'b1;
                            f         <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            f         <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // Starts arriving here are deliberately ignored.
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_ITER) begin
                        state_reg <= DONE;
                        Q         <= q_final;
                        R         <= r_final;
                        ovf       <= ovf_next;
                        dbz       <= 1'b0;
                        f         <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: integer-arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_booth_divider;

    logic        clk;
    logic        rst_n;
    logic [15:0] IN1;
    logic [7:0]  IN2;
    logic        S;
    logic        f;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        ovf;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    booth_divider #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .IN1(IN1), .IN2(IN2), .S(S),
        .f(f), .Q(Q), .R(R), .ovf(ovf), .dbz(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: C-style truncating division, saturated to 8-bit signed.
    function automatic int ref_quot(input logic [15:0] a16, input logic [7:0] b8);
        int a;
        int b;
        a = int'($signed(a16));
        b = int'($signed(b8));
        return a / b;
    endfunction

    function automatic logic [7:0] ref_q(input logic [15:0] a16, input logic [7:0] b8);
        int q;
        q = ref_quot(a16, b8);
        if (q > 127) return 8'h7F;
        if (q < -128) return 8'h80;
        return q[7:0];
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] a16, input logic [7:0] b8);
        int r;
        r = int'($signed(a16)) % int'($signed(b8));
        return r[7:0];
    endfunction

    function automatic logic ref_ovf(input logic [15:0] a16, input logic [7:0] b8);
        int q;
        q = ref_quot(a16, b8);
        return (q > 127) || (q < -128);
    endfunction

    // Protocol model: start on S rising edge when not busy, result 16 edges later.
    logic       m_prev = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_idle = 1'b1;
    int         m_cnt  = 0;
    logic       m_f    = 1'b0;
    logic [7:0] m_Q    = 8'h00;
    logic [7:0] m_R    = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_dbz  = 1'b0;
    logic [7:0] p_Q    = 8'h00;
    logic [7:0] p_R    = 8'h00;
    logic       p_ovf  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_prev <= 1'b0;
            m_busy <= 1'b0;
            m_idle <= 1'b1;
            m_cnt  <= 0;
            m_f    <= 1'b0;
            m_Q    <= 8'h00;
            m_R    <= 8'h00;
            m_ovf  <= 1'b0;
            m_dbz  <= 1'b0;
        end else begin
            m_prev <= S;
            if (S && !m_prev && !m_busy) begin
                m_idle <= 1'b0;
                if (IN2 == 8'h00) begin
                    m_f   <= 1'b1;
                    m_Q   <= 8'h00;
                    m_R   <= 8'h00;
                    m_ovf <= 1'b1;
                    m_dbz <= 1'b1;
                end else begin
                    m_f    <= 1'b0;
                    m_busy <= 1'b1;
                    m_cnt  <= 16;
                    p_Q    <= ref_q(IN1, IN2);
                    p_R    <= ref_r(IN1, IN2);
                    p_ovf  <= ref_ovf(IN1, IN2);
                end
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_f    <= 1'b1;
                    m_Q    <= p_Q;
                    m_R    <= p_R;
                    m_ovf  <= p_ovf;
                    m_dbz  <= 1'b0;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_f", 32'(f), 32'(m_f));
        if (m_f || m_idle) begin
            chk("cyc_Q", 32'(Q), 32'(m_Q));
            chk("cyc_R", 32'(R), 32'(m_R));
            chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
            chk("cyc_dbz", 32'(dbz), 32'(m_dbz));
        end
    end

    // One division; hold = cycles S stays high, pulse_at = RUN cycle of a stray S pulse.
    task automatic do_op(input string nm, input int a, input int b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic eovf, input logic edbz, input int elat,
                         input int hold, input int pulse_at);
        int cyc;
        @(negedge clk);
        IN1 = a[15:0];
        IN2 = b[7:0];
        S   = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && elat > 1) chk({nm, "_fdrop"}, 32'(f), 32'(0));
            if (cyc == hold) S = 1'b0;
            if (cyc == 2) begin
                IN1 = 16'h1234;
                IN2 = 8'h55;
            end
            if (pulse_at > 0 && cyc == pulse_at) S = 1'b1;
            if (pulse_at > 0 && cyc == pulse_at + 1) S = 1'b0;
        end while (!f && cyc < 40);
        S = 1'b0;
        chk({nm, "_lat"}, 32'(cyc), 32'(elat));
        chk({nm, "_Q"}, 32'(Q), 32'(eq));
        chk({nm, "_R"}, 32'(R), 32'(er));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eovf));
        chk({nm, "_dbz"}, 32'(dbz), 32'(edbz));
        $display("op %s: %0d / %0d -> Q=%0h R=%0h ovf=%0b dbz=%0b lat=%0d",
                 nm, a, b, Q, R, ovf, dbz, cyc);
    endtask

    initial begin
        int cyc;
        logic seen_f;
        rst_n = 1'b0;
        S     = 1'b0;
        IN1   = 16'h0000;
        IN2   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_f", 32'(f), 32'(0));
        chk("rst_Q", 32'(Q), 32'(0));
        chk("rst_R", 32'(R), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_dbz", 32'(dbz), 32'(0));
        $display("reset: f=%0b Q=%0h R=%0h ovf=%0b dbz=%0b", f, Q, R, ovf, dbz);
        rst_n = 1'b1;

        do_op("m208_m13",   -208,   -13, 8'h10, 8'h00, 1'b0, 1'b0, 17, 1, 0);
        do_op("100_7",       100,     7, 8'h0E, 8'h02, 1'b0, 1'b0, 17, 1, 0);
        do_op("m100_7",     -100,     7, 8'hF2, 8'hFE, 1'b0, 1'b0, 17, 1, 0);
        do_op("1000_3",     1000,     3, 8'h7F, 8'h01, 1'b1, 1'b0, 17, 1, 0);
        do_op("m32768_m1", -32768,   -1, 8'h7F, 8'h00, 1'b1, 1'b0, 17, 1, 0);
        do_op("16384_m128", 16384, -128, 8'h80, 8'h00, 1'b0, 1'b0, 17, 1, 0);
        do_op("dbz",           5,     0, 8'h00, 8'h00, 1'b1, 1'b1,  1, 1, 0);
        do_op("7_m2",          7,    -2, 8'hFD, 8'h01, 1'b0, 1'b0, 17, 1, 0);
        do_op("m129_1",     -129,     1, 8'h80, 8'h00, 1'b1, 1'b0, 17, 1, 0);
        do_op("127_1",       127,     1, 8'h7F, 8'h00, 1'b0, 1'b0, 17, 1, 0);
        do_op("pulse5",      100,     7, 8'h0E, 8'h02, 1'b0, 1'b0, 17, 1, 5);
        do_op("hold3",      -208,   -13, 8'h10, 8'h00, 1'b0, 1'b0, 17, 3, 0);
        do_op("restart",    1000,     3, 8'h7F, 8'h01, 1'b1, 1'b0, 17, 1, 0);

        // Reset in the middle of a run: no result may ever appear.
        @(negedge clk);
        IN1 = 16'd100;
        IN2 = 8'd7;
        S   = 1'b1;
        @(negedge clk);
        S = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_f = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (f) seen_f = 1'b1;
        end
        chk("abort_nof", 32'(seen_f), 32'(0));
        chk("abort_Q", 32'(Q), 32'(0));
        chk("abort_R", 32'(R), 32'(0));
        chk("abort_ovf", 32'(ovf), 32'(0));
        $display("abort: f_seen=%0b Q=%0h R=%0h ovf=%0b dbz=%0b", seen_f, Q, R, ovf, dbz);

        // S already high when reset releases: the first active edge is a start.
        @(negedge clk);
        rst_n = 1'b0;
        S     = 1'b1;
        IN1   = 16'hFFF9;
        IN2   = 8'd2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) S = 1'b0;
        end while (!f && cyc < 40);
        chk("rststart_lat", 32'(cyc), 32'(17));
        chk("rststart_Q", 32'(Q), 32'(8'hFD));
        chk("rststart_R", 32'(R), 32'(8'hFF));
        chk("rststart_ovf", 32'(ovf), 32'(0));
        $display("op rststart: -7 / 2 -> Q=%0h R=%0h ovf=%0b dbz=%0b lat=%0d",
                 Q, R, ovf, dbz, cyc);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
